demo_1: RTL and testbench
=========================

DEMO_1 -- requirements
Module: demo_1

Interface
REQ-001 Parameter THRESHOLD, default 3: minimum number of asserted votes for Y=1; legal range 1..5.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 A  input  1  vote 0 (1 = yes).
REQ-005 B  input  1  vote 1 (1 = yes).
REQ-006 C  input  1  vote 2 (1 = yes).
REQ-007 D  input  1  vote 3 (1 = yes).
REQ-008 E  input  1  vote 4 (1 = yes).
REQ-009 Y  output  1  registered vote result (1 = motion passes).
REQ-010 count  output  3  registered number of yes votes, 0..5.
REQ-011 all_yes  output  1  registered unanimity flag: all five votes are 1.
REQ-012 all_no  output  1  registered unanimity flag: all five votes are 0.

Function
REQ-013 Each rising clk edge with rst=0 SHALL register count = A+B+C+D+E, unsigned 3-bit; no overflow possible (max 5).
REQ-014 Y SHALL be registered as 1 when (A+B+C+D+E) >= THRESHOLD, else 0, computed from the same-edge samples as count.
REQ-015 all_yes SHALL be registered as 1 exactly when the sum equals 5; all_no exactly when the sum equals 0.
REQ-016 Latency SHALL be exactly one clock: outputs after edge n reflect A..E sampled at edge n; no handshake, a new vote is accepted every cycle.
REQ-017 All outputs SHALL change only on rising clk edges; no combinational path from A..E to any output.
REQ-018 Votes are symmetric: any permutation of A..E SHALL give identical outputs.
REQ-019 With default THRESHOLD=3 the block SHALL be a strict majority voter; ties cannot occur with five voters.
REQ-020 Boundary cases at the threshold: sum = THRESHOLD-1 SHALL give Y=0; sum = THRESHOLD SHALL give Y=1.
REQ-021 THRESHOLD=1 SHALL give Y = NOT all_no; THRESHOLD=5 SHALL give Y = all_yes.
REQ-022 A THRESHOLD value outside 1..5 SHALL be rejected at elaboration.
REQ-023 All inputs are synchronous to clk; the block SHALL NOT include input synchronizers.

Reset
REQ-024 While rst=1 at a rising edge: Y=0, count=0, all_yes=0, all_no=0 after that edge, regardless of A..E.
REQ-025 all_no SHALL read 0 during reset even though count=0; reset values are not a vote result.
REQ-026 On the first edge with rst=0, outputs SHALL reflect the inputs sampled at that edge; no extra warm-up cycle.
REQ-027 Asserting rst mid-operation SHALL clear all outputs at the next edge; no stale vote survives reset.

Verification
REQ-028 rst=1 for 2 cycles with A..E=11111 -> Y=0, count=0, all_yes=0, all_no=0.
REQ-029 With THRESHOLD=3, apply A..E=00000, then 11100, then 10000, then 11111, each held one cycle. Required outputs one cycle later, in order: (Y=0, count=0, all_no=1); (Y=1, count=3); (Y=0, count=1); (Y=1, count=5, all_yes=1).
REQ-030 Exhaustive sweep of all 32 input patterns, one per cycle -> each output on the next cycle equals the popcount/threshold reference model; back-to-back patterns show no skew.
REQ-031 Threshold edge: 00011 then 00111 -> Y=0 then Y=1; repeat with THRESHOLD=5 -> 11110 gives Y=0, 11111 gives Y=1.
REQ-032 Mid-stream reset: 11111 for 3 cycles, rst=1 for 1 cycle, release -> outputs cleared for one cycle, then Y=1, count=5 on the next edge.

Source files
------------

// File: rtl/demo_1.sv
// -----------------------------------------------------------------------------
// demo_1 : five-input registered vote counter with threshold decision
//
// Purpose
//   Counts the yes votes on A..E every rising clock edge and registers the
//   total, a pass/fail decision against THRESHOLD, and two unanimity flags.
//   The latency is exactly one cycle, and a new set of votes is accepted on
//   every edge.
//
// Parameters
//   THRESHOLD  minimum number of yes votes for Y=1 (legal range 1..5)
//
// Ports
//   clk      in   1  single clock, rising-edge active
//   rst      in   1  synchronous active-high reset
//   A..E     in   1  votes 0..4 (1 = yes), synchronous to clk
//   Y        out  1  registered decision (1 = motion passes)
//   count    out  3  registered number of yes votes, 0..5
//   all_yes  out  1  registered flag: all five votes were 1
//   all_no   out  1  registered flag: all five votes were 0
// -----------------------------------------------------------------------------
module demo_1 #(
    parameter int THRESHOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    output logic       Y,
    output logic [2:0] count,
    output logic       all_yes,
    output logic       all_no
);

    // Reject thresholds that could never pass, or that would always pass,
    // before any hardware is built.
    generate
        if (THRESHOLD < 1 || THRESHOLD > 5) begin : g_bad_threshold
            $error("demo_1: THRESHOLD must be in 1..5");
        end
    endgenerate

    localparam logic [2:0] THRESH = 3'(THRESHOLD);

    logic [2:0] vote_sum;

    // The largest possible sum is five, so a 3-bit sum cannot overflow.
    always_comb begin
        vote_sum = {2'b00, A} + {2'b00, B} + {2'b00, C} + {2'b00, D} + {2'b00, E};
    end

    // All outputs come straight from registers, so there is no combinational
    // path from the votes to any output. During reset, all_no is forced to 0
    // as well: the cleared state does not represent a vote result.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y       <= 1'b0;
            count   <= 3'd0;
            all_yes <= 1'b0;
            all_no  <= 1'b0;
        end else begin
            Y       <= (vote_sum >= THRESH);
            count   <= vote_sum;
            all_yes <= (vote_sum == 3'd5);
            all_no  <= (vote_sum == 3'd0);
        end
    end

endmodule

// File: tb/tb_demo_1.sv
// -----------------------------------------------------------------------------
// tb_demo_1 : self-checking bench for demo_1
//
// Three instances with THRESHOLD = 1, 3 and 5 share the same stimulus. Each
// instance is checked against hand-written vectors and against a popcount
// reference model.
// -----------------------------------------------------------------------------
module tb_demo_1;

    localparam int NDUT = 3;
    localparam int THR [NDUT] = '{1, 3, 5};

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] votes;
    logic       y_o       [NDUT];
    logic [2:0] cnt_o     [NDUT];
    logic       all_yes_o [NDUT];
    logic       all_no_o  [NDUT];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // votes[4] is A and votes[0] is E, so a literal reads in A..E order.
    demo_1 #(.THRESHOLD(1)) dut1 (
        .clk(clk), .rst(rst),
        .A(votes[4]), .B(votes[3]), .C(votes[2]), .D(votes[1]), .E(votes[0]),
        .Y(y_o[0]), .count(cnt_o[0]), .all_yes(all_yes_o[0]), .all_no(all_no_o[0])
    );

    demo_1 #(.THRESHOLD(3)) dut3 (
        .clk(clk), .rst(rst),
        .A(votes[4]), .B(votes[3]), .C(votes[2]), .D(votes[1]), .E(votes[0]),
        .Y(y_o[1]), .count(cnt_o[1]), .all_yes(all_yes_o[1]), .all_no(all_no_o[1])
    );

    demo_1 #(.THRESHOLD(5)) dut5 (
        .clk(clk), .rst(rst),
        .A(votes[4]), .B(votes[3]), .C(votes[2]), .D(votes[1]), .E(votes[0]),
        .Y(y_o[2]), .count(cnt_o[2]), .all_yes(all_yes_o[2]), .all_no(all_no_o[2])
    );

    typedef struct {
        logic       rst;
        logic [4:0] votes;
        logic       y1;
        logic       y3;
        logic       y5;
        logic [2:0] count;
        logic       all_yes;
        logic       all_no;
    } vec_t;

    vec_t vecs [10];

    // Drives the inputs on the falling edge, then waits until just after the
    // next rising edge, which is when the registered outputs reflect them.
    task automatic applyStimulus(input logic r, input logic [4:0] v);
        @(negedge clk);
        rst   = r;
        votes = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input string field, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s %s: got %0d expected %0d", tag, field, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic ey[NDUT], input logic [2:0] ec,
                            input logic eay, input logic ean);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput(tag, $sformatf("Y(T=%0d)", THR[i]), int'(y_o[i]), int'(ey[i]));
            checkOutput(tag, $sformatf("count(T=%0d)", THR[i]), int'(cnt_o[i]), int'(ec));
            checkOutput(tag, $sformatf("all_yes(T=%0d)", THR[i]), int'(all_yes_o[i]), int'(eay));
            checkOutput(tag, $sformatf("all_no(T=%0d)", THR[i]), int'(all_no_o[i]), int'(ean));
        end
    endtask

    // Reference model: outputs follow directly from the number of yes votes.
    task automatic checkModel(input string tag, input logic r, input logic [4:0] v);
        logic ey[NDUT];
        int   n;
        n = r ? 0 : $countones(v);
        for (int i = 0; i < NDUT; i++) ey[i] = !r && (n >= THR[i]);
        checkAll(tag, ey, 3'(n), !r && (n == 5), !r && (n == 0));
    endtask

    task automatic checkVec(input string tag, input vec_t t);
        logic ey[NDUT];
        ey[0] = t.y1;
        ey[1] = t.y3;
        ey[2] = t.y5;
        checkAll(tag, ey, t.count, t.all_yes, t.all_no);
    endtask

    initial begin
        logic [4:0] rv;
        logic       rr;

        rst   = 1'b1;
        votes = 5'b00000;

        //          rst    votes      y1    y3    y5    count  ay    an
        vecs[0] = '{1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 5'b11100, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 5'b10000, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 5'b11111, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 5'b00011, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 5'b00111, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 5'b11110, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 5'b11111, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].votes);
            checkVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Mid-stream reset: a full vote held, then one reset cycle, then release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'b11111);
            checkModel($sformatf("pre_rst%0d", i), 1'b0, 5'b11111);
        end
        applyStimulus(1'b1, 5'b11111);
        checkVec("mid_rst", '{1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
        applyStimulus(1'b0, 5'b11111);
        checkVec("post_rst", '{1'b0, 5'b11111, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0});

        // Exhaustive sweep of all patterns, back to back.
        for (int p = 0; p < 32; p++) begin
            applyStimulus(1'b0, 5'(p));
            checkModel($sformatf("sweep%0d", p), 1'b0, 5'(p));
        end

        // Random stimulus with occasional resets.
        for (int k = 0; k < 200; k++) begin
            rv = 5'($urandom_range(0, 31));
            rr = ($urandom_range(0, 15) == 0);
            applyStimulus(rr, rv);
            checkModel($sformatf("rand%0d", k), rr, rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
